// File: rtl/issue_scheduler.sv
// Two-wide issue scheduler: steers slot-prioritised candidates onto two ALU lanes,
// one memory lane and a non-pipelined divider, returning per-candidate acks.
module issue_scheduler #(
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned DIV_LAT   = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [1:0]                cand_valid,
  input  logic [1:0][1:0]           cand_unit,
  input  logic [1:0][TAG_W-1:0]     cand_tag,
  input  logic [1:0][PAYLOAD_W-1:0] cand_payload,
  output logic [1:0]                issue_ack,
  output logic [1:0]                alu_valid,
  output logic [1:0][TAG_W-1:0]     alu_tag,
  output logic [1:0][PAYLOAD_W-1:0] alu_payload,
  input  logic [1:0]                alu_ready,
  output logic                      mem_valid,
  output logic [TAG_W-1:0]          mem_tag,
  output logic [PAYLOAD_W-1:0]      mem_payload,
  input  logic                      mem_ready,
  output logic                      div_start,
  output logic [PAYLOAD_W-1:0]      div_payload,
  output logic                      div_done,
  output logic [TAG_W-1:0]          div_done_tag,
  output logic                      illegal_unit,
  output logic [15:0]               stall_count
);

  typedef enum logic [1:0] {U_ALU = 2'd0, U_MEM = 2'd1, U_DIV = 2'd2, U_ILL = 2'd3} unit_e;

  logic [1:0]                r_alu_valid;
  logic [1:0][TAG_W-1:0]     r_alu_tag;
  logic [1:0][PAYLOAD_W-1:0] r_alu_payload;
  logic                      r_mem_valid;
  logic [TAG_W-1:0]          r_mem_tag;
  logic [PAYLOAD_W-1:0]      r_mem_payload;
  logic                      r_div_start;
  logic [PAYLOAD_W-1:0]      r_div_payload;
  logic                      r_div_done;
  logic [TAG_W-1:0]          r_div_tag;
  logic [7:0]                r_div_cnt;
  logic                      r_illegal;
  logic [15:0]               r_stall;

  logic [1:0] w_alu_free;
  logic       w_mem_free;
  logic       w_div_idle;
  logic [1:0] w_alloc;
  logic [1:0] w_ack;
  logic [1:0] w_alu_load;
  logic [1:0] w_alu_src;
  logic       w_mem_load;
  logic       w_mem_src;
  logic       w_div_load;
  logic       w_div_src;
  logic       w_illegal;
  logic       w_stall;

  assign w_alu_free = ~r_alu_valid | alu_ready;
  assign w_mem_free = ~r_mem_valid | mem_ready;
  // Divider is also held off during the done cycle so the next divide starts after div_done.
  assign w_div_idle = (r_div_cnt == 8'd0) && !r_div_done;

  always_comb begin
    w_alloc    = '0;
    w_alu_load = '0;
    w_alu_src  = '0;
    w_mem_load = 1'b0;
    w_mem_src  = 1'b0;
    w_div_load = 1'b0;
    w_div_src  = 1'b0;
    w_illegal  = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (cand_valid[i]) begin
        unique case (unit_e'(cand_unit[i]))
          U_ALU: begin
            if (w_alu_free[0] && !w_alu_load[0]) begin
              w_alu_load[0] = 1'b1;
              w_alu_src[0]  = i[0];
              w_alloc[i]    = 1'b1;
            end else if (w_alu_free[1] && !w_alu_load[1]) begin
              w_alu_load[1] = 1'b1;
              w_alu_src[1]  = i[0];
              w_alloc[i]    = 1'b1;
            end
          end
          U_MEM: begin
            if (w_mem_free && !w_mem_load) begin
              w_mem_load = 1'b1;
              w_mem_src  = i[0];
              w_alloc[i] = 1'b1;
            end
          end
          U_DIV: begin
            if (w_div_idle && !w_div_load) begin
              w_div_load = 1'b1;
              w_div_src  = i[0];
              w_alloc[i] = 1'b1;
            end
          end
          U_ILL: w_illegal = 1'b1;
        endcase
      end
    end
    w_ack   = w_alloc & cand_valid & {2{~flush}};
    w_stall = (|(cand_valid & ~w_ack)) && !flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_valid   <= '0;
      r_alu_tag     <= '0;
      r_alu_payload <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_tag     <= '0;
      r_mem_payload <= '0;
    end else begin
      for (int unsigned j = 0; j < 2; j++) begin
        if (flush) begin
          r_alu_valid[j] <= 1'b0;
        end else if (w_alu_load[j]) begin
          r_alu_valid[j]   <= 1'b1;
          r_alu_tag[j]     <= cand_tag[w_alu_src[j]];
          r_alu_payload[j] <= cand_payload[w_alu_src[j]];
        end else if (alu_ready[j]) begin
          r_alu_valid[j] <= 1'b0;
        end
      end
      if (flush) begin
        r_mem_valid <= 1'b0;
      end else if (w_mem_load) begin
        r_mem_valid   <= 1'b1;
        r_mem_tag     <= cand_tag[w_mem_src];
        r_mem_payload <= cand_payload[w_mem_src];
      end else if (mem_ready) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_start   <= 1'b0;
      r_div_payload <= '0;
      r_div_done    <= 1'b0;
      r_div_tag     <= '0;
      r_div_cnt     <= '0;
    end else if (flush) begin
      r_div_start <= 1'b0;
      r_div_done  <= 1'b0;
      r_div_cnt   <= '0;
    end else begin
      r_div_start <= w_div_load;
      r_div_done  <= (r_div_cnt == 8'd1);
      if (w_div_load) begin
        r_div_payload <= cand_payload[w_div_src];
        r_div_tag     <= cand_tag[w_div_src];
        r_div_cnt     <= 8'(DIV_LAT);
      end else if (r_div_cnt != 8'd0) begin
        r_div_cnt <= r_div_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal <= 1'b0;
      r_stall   <= '0;
    end else begin
      if (w_illegal) r_illegal <= 1'b1;
      if (w_stall && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
    end
  end

  assign issue_ack    = w_ack;
  assign alu_valid    = r_alu_valid;
  assign alu_tag      = r_alu_tag;
  assign alu_payload  = r_alu_payload;
  assign mem_valid    = r_mem_valid;
  assign mem_tag      = r_mem_tag;
  assign mem_payload  = r_mem_payload;
  assign div_start    = r_div_start;
  assign div_payload  = r_div_payload;
  assign div_done     = r_div_done;
  assign div_done_tag = r_div_tag;
  assign illegal_unit = r_illegal;
  assign stall_count  = r_stall;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: hand-computed acks, lane contents,
// divider timing, flush, illegal-unit and stall saturation.
module tb_issue_scheduler;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned PW    = 128;

  localparam logic [1:0] ALU = 2'd0, MEM = 2'd1, DIV = 2'd2, ILL = 2'd3;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic [1:0]           cand_valid;
  logic [1:0][1:0]      cand_unit;
  logic [1:0][TAG_W-1:0] cand_tag;
  logic [1:0][PW-1:0]   cand_payload;
  logic [1:0]           issue_ack;
  logic [1:0]           alu_valid;
  logic [1:0][TAG_W-1:0] alu_tag;
  logic [1:0][PW-1:0]   alu_payload;
  logic [1:0]           alu_ready;
  logic                 mem_valid;
  logic [TAG_W-1:0]     mem_tag;
  logic [PW-1:0]        mem_payload;
  logic                 mem_ready;
  logic                 div_start;
  logic [PW-1:0]        div_payload;
  logic                 div_done;
  logic [TAG_W-1:0]     div_done_tag;
  logic                 illegal_unit;
  logic [15:0]          stall_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_stall = 0;

  issue_scheduler #(.TAG_W(TAG_W), .PAYLOAD_W(PW), .DIV_LAT(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .cand_valid(cand_valid), .cand_unit(cand_unit), .cand_tag(cand_tag),
    .cand_payload(cand_payload), .issue_ack(issue_ack),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_payload(alu_payload),
    .alu_ready(alu_ready), .mem_valid(mem_valid), .mem_tag(mem_tag),
    .mem_payload(mem_payload), .mem_ready(mem_ready), .div_start(div_start),
    .div_payload(div_payload), .div_done(div_done), .div_done_tag(div_done_tag),
    .illegal_unit(illegal_unit), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cand(input int slot, input logic [1:0] unit, input logic [TAG_W-1:0] tag,
                          input logic [PW-1:0] pl);
    cand_valid[slot]   = 1'b1;
    cand_unit[slot]    = unit;
    cand_tag[slot]     = tag;
    cand_payload[slot] = pl;
  endtask

  task automatic clear_cands();
    cand_valid   = '0;
    cand_unit    = '0;
    cand_tag     = '0;
    cand_payload = '0;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    alu_ready = '0;
    mem_ready = 1'b0;
    clear_cands();
    #2;
    chk("rst_alu_valid", alu_valid, 2'b00);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_div_done", div_done, 1'b0);
    chk("rst_illegal", illegal_unit, 1'b0);
    chk("rst_stall", stall_count, 16'd0);
    step();
    reset_n = 1'b1;

    // Two ALU candidates into empty lanes
    set_cand(0, ALU, 6'd5, 128'hA5);
    set_cand(1, ALU, 6'd3, 128'hB3);
    #1 chk("alu2_ack", issue_ack, 2'b11);
    step(); clear_cands();
    chk("alu2_valid", alu_valid, 2'b11);
    chk("alu2_tag0", alu_tag[0], 6'd5);
    chk("alu2_tag1", alu_tag[1], 6'd3);
    chk("alu2_pl1", alu_payload[1], 128'hB3);
    chk("alu2_stall", stall_count, 16'(exp_stall));

    // Drain ALU1 only
    alu_ready = 2'b10;
    step();
    chk("alu1_drain", alu_valid, 2'b01);

    // ALU0 blocked, ALU1 empty: slot 0 goes to ALU1, slot 1 stalls
    alu_ready = 2'b00;
    set_cand(0, ALU, 6'd9, 128'h99);
    set_cand(1, ALU, 6'd10, 128'h1010);
    #1 chk("alu_blk_ack", issue_ack, 2'b01);
    step(); clear_cands(); exp_stall++;
    chk("alu_blk_valid", alu_valid, 2'b11);
    chk("alu_blk_tag0", alu_tag[0], 6'd5);
    chk("alu_blk_tag1", alu_tag[1], 6'd9);
    chk("alu_blk_pl0", alu_payload[0], 128'hA5);
    chk("alu_blk_stall", stall_count, 16'(exp_stall));

    alu_ready = 2'b11;
    step();
    chk("alu_empty", alu_valid, 2'b00);

    // Memory lane: fill, then drain+refill with two MEM candidates
    set_cand(0, MEM, 6'd1, 128'h11);
    #1 chk("mem_fill_ack", issue_ack, 2'b01);
    step(); clear_cands();
    chk("mem_fill_tag", mem_tag, 6'd1);
    mem_ready = 1'b1;
    set_cand(0, MEM, 6'd7, 128'h77);
    set_cand(1, MEM, 6'd2, 128'h22);
    #1 chk("mem2_ack", issue_ack, 2'b01);
    step(); clear_cands(); exp_stall++;
    chk("mem2_valid", mem_valid, 1'b1);
    chk("mem2_tag", mem_tag, 6'd7);
    chk("mem2_stall", stall_count, 16'(exp_stall));
    mem_ready = 1'b0;
    set_cand(0, MEM, 6'd4, 128'h44);
    #1 chk("mem_full_ack", issue_ack, 2'b00);
    step(); clear_cands(); exp_stall++;
    chk("mem_hold_tag", mem_tag, 6'd7);
    chk("mem_hold_pl", mem_payload, 128'h77);
    chk("mem_hold_stall", stall_count, 16'(exp_stall));
    mem_ready = 1'b1;
    step();
    chk("mem_drain", mem_valid, 1'b0);

    // Divider occupancy: accept at cycle 0, done at cycle 9, re-accept at cycle 10
    set_cand(0, DIV, 6'd12, 128'hD12);
    #1 chk("div0_ack", issue_ack, 2'b01);
    step(); clear_cands();
    for (int c = 1; c <= 10; c++) begin
      chk("div_start", div_start, c == 1);
      if (c == 1) chk("div_payload", div_payload, 128'hD12);
      chk("div_done", div_done, c == 9);
      if (c == 9) chk("div_done_tag", div_done_tag, 6'd12);
      if (c == 5) begin
        set_cand(0, DIV, 6'd13, 128'hD13);
        #1 chk("div_busy_ack", issue_ack, 2'b00);
        exp_stall++;
      end
      if (c == 10) begin
        set_cand(0, DIV, 6'd14, 128'hD14);
        #1 chk("div_again_ack", issue_ack, 2'b01);
      end
      step(); clear_cands();
    end
    chk("div_stall", stall_count, 16'(exp_stall));

    // Flush during a divide
    chk("div2_start", div_start, 1'b1);
    step();
    alu_ready = 2'b00;
    set_cand(0, ALU, 6'd22, 128'h2222);
    #1 chk("pre_flush_ack", issue_ack, 2'b01);
    step(); clear_cands();
    chk("pre_flush_valid", alu_valid, 2'b01);
    flush = 1'b1;
    set_cand(0, ALU, 6'd20, 128'h20);
    set_cand(1, MEM, 6'd21, 128'h21);
    #1 chk("flush_ack", issue_ack, 2'b00);
    step(); clear_cands();
    flush = 1'b0;
    chk("flush_alu_valid", alu_valid, 2'b00);
    chk("flush_mem_valid", mem_valid, 1'b0);
    chk("flush_stall", stall_count, 16'(exp_stall));
    alu_ready = 2'b11;
    for (int c = 0; c < 16; c++) begin
      chk("flush_no_done", div_done, 1'b0);
      step();
    end

    // Illegal unit on slot 0 while slot 1 ALU issues out of order
    set_cand(0, ILL, 6'd0, 128'h0);
    set_cand(1, ALU, 6'd30, 128'h30);
    #1 chk("ill_ack", issue_ack, 2'b10);
    step(); exp_stall++;
    cand_valid[1] = 1'b0;
    chk("ill_sticky", illegal_unit, 1'b1);
    chk("ill_alu_tag0", alu_tag[0], 6'd30);
    chk("ill_stall", stall_count, 16'(exp_stall));
    #1 chk("ill_hold_ack", issue_ack, 2'b00);
    repeat (70000) @(posedge clk);
    #1;
    chk("stall_sat", stall_count, 16'hFFFF);
    chk("ill_still", illegal_unit, 1'b1);
    clear_cands();

    // Reset mid-divide
    set_cand(0, DIV, 6'd33, 128'h33);
    #1 chk("rdiv_ack", issue_ack, 2'b01);
    step(); clear_cands();
    step(); step();
    reset_n = 1'b0;
    #1;
    chk("rst2_illegal", illegal_unit, 1'b0);
    chk("rst2_stall", stall_count, 16'd0);
    chk("rst2_div_start", div_start, 1'b0);
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      chk("rst2_no_done", div_done, 1'b0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
